// File: rtl/game_frame_controller.sv
// -----------------------------------------------------------------------------
// game_frame_controller
//
// Frame-synchronous supervisor for the N x N tile game. Conditions the four
// pushbuttons (synchronise, debounce per frame, single priority direction,
// hold auto-repeat), issues move requests to the game-logic engine over a
// req/ack handshake, and commits returned grids to the display register only
// on vsync rising edges so the renderer never sees a half-updated frame.
// Also detects win / game-over and sequences WELCOME -> PLAY -> WON/LOST.
//
// Ports
//   clk          system / pixel clock
//   reset        synchronous, active-high reset
//   vsync        vertical sync from the VGA timing generator
//   btn          raw buttons {right,left,down,up}, asynchronous
//   welcome_grid animated welcome pattern, shown while in WELCOME
//   next_grid    grid produced by the game logic, valid with move_ack
//   move_ack     one-cycle pulse: move finished, next_grid valid
//   move_req     request level, held until move_ack
//   move_dir     0 up, 1 down, 2 left, 3 right; stable while move_req
//   new_game     one-cycle pulse on entering PLAY
//   grid         displayed grid; tile idx = r*GRID_N+c at bits idx*TILE_BITS
//   state        0 WELCOME, 1 PLAY, 2 WAIT_ACK, 3 WON, 4 LOST
//   frame_tick   one-cycle strobe per vsync rising edge
// -----------------------------------------------------------------------------
module game_frame_controller #(
  parameter int GRID_N          = 4,
  parameter int TILE_BITS       = 4,
  parameter int WIN_EXP         = 11,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_FRAMES   = 12,
  parameter int END_HOLD_FRAMES = 60
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 vsync,
  input  logic [3:0]                           btn,
  input  logic [GRID_N*GRID_N*TILE_BITS-1:0]   welcome_grid,
  input  logic [GRID_N*GRID_N*TILE_BITS-1:0]   next_grid,
  input  logic                                 move_ack,
  output logic                                 move_req,
  output logic [1:0]                           move_dir,
  output logic                                 new_game,
  output logic [GRID_N*GRID_N*TILE_BITS-1:0]   grid,
  output logic [2:0]                           state,
  output logic                                 frame_tick
);

  localparam int NTILES = GRID_N * GRID_N;
  localparam int GRID_W = NTILES * TILE_BITS;
  localparam int DB_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RP_W   = (REPEAT_FRAMES > 0) ? $clog2(REPEAT_FRAMES + 1) : 1;
  localparam int EH_W   = (END_HOLD_FRAMES > 0) ? $clog2(END_HOLD_FRAMES + 1) : 1;

  localparam logic [DB_W-1:0]      DB_MAX    = DB_W'(DEBOUNCE_FRAMES);
  localparam logic [RP_W-1:0]      RP_MAX    = RP_W'(REPEAT_FRAMES);
  localparam logic [EH_W-1:0]      EH_MAX    = EH_W'(END_HOLD_FRAMES);
  localparam logic [TILE_BITS-1:0] WIN_TILE  = TILE_BITS'(WIN_EXP);
  localparam bit                   REPEAT_EN = (REPEAT_FRAMES > 0);

  typedef enum logic [2:0] {
    S_WELCOME  = 3'd0,
    S_PLAY     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WON      = 3'd3,
    S_LOST     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_vsync_prev;
  logic                r_frame_tick;
  logic [3:0]          r_btn_s1;
  logic [3:0]          r_btn_s2;
  logic [DB_W-1:0]     r_db_cnt [4];
  logic                r_held_valid;
  logic [1:0]          r_held_dir;
  logic [RP_W-1:0]     r_rep_cnt;
  logic [EH_W-1:0]     r_end_cnt;
  logic [GRID_W-1:0]   r_grid;
  logic [GRID_W-1:0]   r_pending;
  logic                r_pending_valid;
  logic                r_check;
  logic                r_move_req;
  logic [1:0]          r_move_dir;
  logic                r_new_game;

  logic [DB_W-1:0]     w_db_nxt [4];
  logic [3:0]          w_down;
  logic                w_any_down;
  logic [1:0]          w_pri_dir;
  logic                w_fresh;
  logic                w_repeat;
  logic                w_event;
  logic                w_end_done;
  logic [TILE_BITS-1:0] w_tile [NTILES];
  logic                w_win;
  logic                w_has_zero;
  logic                w_has_pair;
  logic                w_lost;

  // ---------------------------------------------------------------------------
  // Button conditioning. The debounce counts are evaluated with the value they
  // will hold after this tick, so a button reads "down" on the very tick that
  // its count reaches DEBOUNCE_FRAMES.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    w_down     = '0;
    w_pri_dir  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r_btn_s2[i])              w_db_nxt[i] = '0;
      else if (r_db_cnt[i] == DB_MAX) w_db_nxt[i] = DB_MAX;
      else                           w_db_nxt[i] = r_db_cnt[i] + 1'b1;
      w_down[i] = (w_db_nxt[i] == DB_MAX);
    end
    w_any_down = |w_down;
    // Priority up > down > left > right; the bit index doubles as move_dir.
    if      (w_down[0]) w_pri_dir = 2'd0;
    else if (w_down[1]) w_pri_dir = 2'd1;
    else if (w_down[2]) w_pri_dir = 2'd2;
    else                w_pri_dir = 2'd3;

    // A change of the leading button counts as a brand-new press.
    w_fresh  = r_frame_tick && w_any_down &&
               (!r_held_valid || (r_held_dir != w_pri_dir));
    w_repeat = REPEAT_EN && r_frame_tick && w_any_down && r_held_valid &&
               (r_held_dir == w_pri_dir) && ((r_rep_cnt + 1'b1) == RP_MAX);
    w_event  = w_fresh || w_repeat;
  end

  assign w_end_done = (r_end_cnt == EH_MAX);

  // ---------------------------------------------------------------------------
  // Win / game-over evaluation on the displayed grid. Only acted on in the
  // cycle after a commit (r_check).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_win      = 1'b0;
    w_has_zero = 1'b0;
    w_has_pair = 1'b0;
    for (int i = 0; i < NTILES; i++) begin
      w_tile[i] = r_grid[i*TILE_BITS +: TILE_BITS];
      if (w_tile[i] == WIN_TILE) w_win      = 1'b1;
      if (w_tile[i] == '0)       w_has_zero = 1'b1;
    end
    // Loop bounds stop one short so the neighbour index is always in range.
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N - 1; c++) begin
        if (w_tile[r*GRID_N+c] != '0 && w_tile[r*GRID_N+c] == w_tile[r*GRID_N+c+1])
          w_has_pair = 1'b1;
      end
    end
    for (int r = 0; r < GRID_N - 1; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (w_tile[r*GRID_N+c] != '0 && w_tile[r*GRID_N+c] == w_tile[(r+1)*GRID_N+c])
          w_has_pair = 1'b1;
      end
    end
    w_lost = !w_has_zero && !w_has_pair;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WELCOME: if (w_event) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if      (r_check && w_win)  w_state_nxt = S_WON;
        else if (r_check && w_lost) w_state_nxt = S_LOST;
        else if (w_event)           w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An earlier move can commit while this one is in flight; an end of
        // game then drops the outstanding request.
        if      (r_check && w_win)  w_state_nxt = S_WON;
        else if (r_check && w_lost) w_state_nxt = S_LOST;
        else if (move_ack)          w_state_nxt = S_PLAY;
      end
      // Only a fresh press leaves the end screen, so a button held through
      // the hold-off period cannot skip it via auto-repeat.
      S_WON, S_LOST: if (w_end_done && w_fresh) w_state_nxt = S_WELCOME;
      default: w_state_nxt = S_WELCOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WELCOME;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_prev    <= 1'b0;
      r_frame_tick    <= 1'b0;
      r_btn_s1        <= '0;
      r_btn_s2        <= '0;
      r_db_cnt        <= '{default: '0};
      r_held_valid    <= 1'b0;
      r_held_dir      <= 2'd0;
      r_rep_cnt       <= '0;
      r_end_cnt       <= '0;
      r_grid          <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_check         <= 1'b0;
      r_move_req      <= 1'b0;
      r_move_dir      <= 2'd0;
      r_new_game      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here samples pre-edge values, independent of statement order.
      r_vsync_prev <= vsync;
      r_frame_tick <= vsync & ~r_vsync_prev;
      r_btn_s1     <= btn;
      r_btn_s2     <= r_btn_s1;
      r_new_game   <= 1'b0;
      r_check      <= 1'b0;

      if (r_frame_tick) begin
        for (int i = 0; i < 4; i++) r_db_cnt[i] <= w_db_nxt[i];
        if (!w_any_down) begin
          r_held_valid <= 1'b0;
          r_rep_cnt    <= '0;
        end else if (w_event) begin
          r_held_valid <= 1'b1;
          r_held_dir   <= w_pri_dir;
          r_rep_cnt    <= '0;
        end else if (r_rep_cnt != RP_MAX) begin
          r_rep_cnt <= r_rep_cnt + 1'b1;
        end
      end

      if (r_state == S_WON || r_state == S_LOST) begin
        if (r_frame_tick && !w_end_done) r_end_cnt <= r_end_cnt + 1'b1;
      end else begin
        r_end_cnt <= '0;
      end

      // Commit uses the pending flag as it stood before this edge, so an ack
      // landing on a tick waits for the following tick.
      if ((r_state == S_PLAY || r_state == S_WAIT_ACK) && r_frame_tick && r_pending_valid) begin
        r_grid          <= r_pending;
        r_pending_valid <= 1'b0;
        r_check         <= 1'b1;
      end

      case (r_state)
        S_WELCOME: begin
          if (w_state_nxt == S_PLAY) begin
            r_grid          <= '0;
            r_new_game      <= 1'b1;
            r_pending_valid <= 1'b0;
          end else if (r_frame_tick) begin
            r_grid <= welcome_grid;
          end
        end
        S_PLAY: begin
          if (w_state_nxt == S_WAIT_ACK) begin
            r_move_req <= 1'b1;
            r_move_dir <= w_pri_dir;
          end
        end
        S_WAIT_ACK: begin
          if (w_state_nxt != S_WAIT_ACK) r_move_req <= 1'b0;
          if (w_state_nxt == S_PLAY) begin
            r_pending       <= next_grid;
            r_pending_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign move_req   = r_move_req;
  assign move_dir   = r_move_dir;
  assign new_game   = r_new_game;
  assign grid       = r_grid;
  assign state      = r_state;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_game_frame_controller.sv
// -----------------------------------------------------------------------------
// tb_game_frame_controller
//
// Directed bench for game_frame_controller with default parameters. vsync is
// produced one frame at a time by do_tick(); a per-cycle monitor in cyc()
// counts frame ticks, new_game pulses and move_req rising edges, and can
// answer requests automatically for the auto-repeat scenario.
// -----------------------------------------------------------------------------
module tb_game_frame_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [3:0]  btn;
  logic [63:0] welcome_grid;
  logic [63:0] next_grid;
  logic        move_ack;
  logic        move_req;
  logic [1:0]  move_dir;
  logic        new_game;
  logic [63:0] grid;
  logic [2:0]  state;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  bit          prev_req  = 1'b0;
  bit          auto_ack  = 1'b0;
  int          req_rises = 0;
  int          ng_pulses = 0;
  int          tick_cnt  = 0;
  int          ack_timer = 0;
  int          t0        = 0;
  logic [63:0] ack_grid  = '0;
  int          rise_tick [8];
  logic [1:0]  rise_dir  [8];

  localparam logic [63:0] WELCOME_PAT = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] GRID_HPAIR  = 64'h1212_2121_1212_2133;
  localparam logic [63:0] GRID_VPAIR  = 64'h1212_2121_1213_2123;
  localparam logic [63:0] GRID_DEAD   = 64'h1212_2121_1212_2121;
  localparam logic [63:0] GRID_WIN    = 64'h0000_0000_0000_0B00;

  game_frame_controller dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .btn          (btn),
    .welcome_grid (welcome_grid),
    .next_grid    (next_grid),
    .move_ack     (move_ack),
    .move_req     (move_req),
    .move_dir     (move_dir),
    .new_game     (new_game),
    .grid         (grid),
    .state        (state),
    .frame_tick   (frame_tick)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then optionally drive the ack.
  task automatic cyc();
    @(negedge clk);
    if (frame_tick) tick_cnt++;
    if (new_game)   ng_pulses++;
    if (move_req && !prev_req) begin
      if (req_rises < 8) begin
        rise_tick[req_rises] = tick_cnt;
        rise_dir[req_rises]  = move_dir;
      end
      req_rises++;
      ack_timer = 0;
    end
    prev_req = move_req;
    if (auto_ack) begin
      move_ack = 1'b0;
      if (move_req) begin
        ack_timer++;
        if (ack_timer == 3) begin
          next_grid = ack_grid;
          move_ack  = 1'b1;
        end
      end
    end
  endtask

  // One video frame: idle, vsync high for 3 clocks, then low.
  task automatic do_tick();
    repeat (4) cyc();
    vsync = 1'b1;
    repeat (3) cyc();
    vsync = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic enter_play();
    btn = 4'b0001;
    do_tick();
    do_tick();
    btn = 4'b0000;
    do_tick();
  endtask

  // Press, debounce, answer the request off-tick, then commit on next frame.
  task automatic do_move(input string tag, input logic [3:0] b, input logic [1:0] d,
                         input logic [63:0] g);
    btn = b;
    do_tick();
    do_tick();
    btn = 4'b0000;
    check({tag, "_req"}, move_req, 1'b1);
    check({tag, "_dir"}, move_dir, d);
    next_grid = g;
    move_ack  = 1'b1;
    cyc();
    move_ack  = 1'b0;
    cyc();
    do_tick();
  endtask

  initial begin
    reset        = 1'b1;
    vsync        = 1'b0;
    btn          = 4'b0000;
    move_ack     = 1'b0;
    next_grid    = '0;
    welcome_grid = WELCOME_PAT;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state
    check("rst_state", state, 3'd0);
    check("rst_grid", grid, 64'h0);
    check("rst_req", move_req, 1'b0);
    check("rst_dir", move_dir, 2'd0);
    check("rst_newgame", new_game, 1'b0);
    check("rst_tick", frame_tick, 1'b0);

    // WELCOME shows the welcome pattern on each tick
    do_tick();
    check("welcome_load", grid, WELCOME_PAT);

    // Debounced up press leaves WELCOME without a move request
    ng_pulses = 0;
    btn = 4'b0001;
    do_tick();
    check("debounce_1tick", state, 3'd0);
    do_tick();
    check("play_state", state, 3'd1);
    check("play_grid", grid, 64'h0);
    btn = 4'b0000;
    do_tick();
    check("newgame_once", ng_pulses, 1);
    check("no_req_on_start", req_rises, 0);

    // Up+left: priority picks up; ack off-tick, commit on next tick
    btn = 4'b0101;
    do_tick();
    do_tick();
    btn = 4'b0000;
    check("pri_req", move_req, 1'b1);
    check("pri_dir", move_dir, 2'd0);
    check("wait_state", state, 3'd2);
    next_grid = 64'h1;
    move_ack  = 1'b1;
    cyc();
    move_ack  = 1'b0;
    check("ack_state", state, 3'd1);
    check("ack_req_drop", move_req, 1'b0);
    check("grid_before_tick", grid, 64'h0);
    do_tick();
    check("grid_committed", grid, 64'h1);
    check("play_after_commit", state, 3'd1);

    // Down press; ack lands on the tick cycle and must wait one more frame
    btn = 4'b0010;
    do_tick();
    do_tick();
    btn = 4'b0000;
    check("down_dir", move_dir, 2'd1);
    vsync = 1'b1;
    cyc();
    check("tick_strobe", frame_tick, 1'b1);
    next_grid = 64'h2;
    move_ack  = 1'b1;
    cyc();
    move_ack  = 1'b0;
    check("tick_one_cycle", frame_tick, 1'b0);
    check("ack_at_tick_state", state, 3'd1);
    cyc();
    vsync = 1'b0;
    check("no_same_tick_commit", grid, 64'h1);
    do_tick();
    check("next_tick_commit", grid, 64'h2);

    // Right held: fresh press then repeats every 12 frames
    req_rises = 0;
    ack_grid  = 64'h2;
    auto_ack  = 1'b1;
    t0        = tick_cnt;
    btn       = 4'b1000;
    repeat (41) do_tick();
    btn = 4'b0000;
    do_tick();
    auto_ack = 1'b0;
    move_ack = 1'b0;
    check("repeat_count", req_rises, 4);
    check("repeat_first", rise_tick[0] - t0, 2);
    for (int i = 1; i < 4; i++)
      check($sformatf("repeat_gap%0d", i), rise_tick[i] - rise_tick[0], 12 * i);
    for (int i = 0; i < 4; i++)
      check($sformatf("repeat_dir%0d", i), rise_dir[i], 2'd3);
    check("repeat_state", state, 3'd1);

    // Full grids that still hold a merge keep playing
    do_move("hpair", 4'b0001, 2'd0, GRID_HPAIR);
    check("hpair_state", state, 3'd1);
    do_move("vpair", 4'b0001, 2'd0, GRID_VPAIR);
    check("vpair_state", state, 3'd1);
    check("vpair_grid", grid, GRID_VPAIR);

    // Winning tile; presses ignored for the hold-off, then release+press
    do_move("win", 4'b0001, 2'd0, GRID_WIN);
    check("won_state", state, 3'd3);
    for (int k = 1; k <= 60; k++) begin
      btn = (k <= 10) ? 4'b0001 : 4'b0000;
      do_tick();
      if (k == 10) check("won_press_ignored", state, 3'd3);
    end
    check("won_after_hold", state, 3'd3);
    check("won_grid_held", grid, GRID_WIN);
    btn = 4'b0001;
    do_tick();
    do_tick();
    check("won_to_welcome", state, 3'd0);
    btn = 4'b0000;
    do_tick();

    // Full checkerboard without merges is game over
    enter_play();
    check("replay_state", state, 3'd1);
    do_move("dead", 4'b0100, 2'd2, GRID_DEAD);
    check("lost_state", state, 3'd4);

    // Reset in the middle of WAIT_ACK; a late ack is ignored
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    enter_play();
    btn = 4'b0001;
    do_tick();
    do_tick();
    btn = 4'b0000;
    check("pre_rst_wait", state, 3'd2);
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    check("midrst_state", state, 3'd0);
    check("midrst_req", move_req, 1'b0);
    check("midrst_grid", grid, 64'h0);
    next_grid = 64'hB;
    move_ack  = 1'b1;
    cyc();
    move_ack  = 1'b0;
    cyc();
    check("late_ack_state", state, 3'd0);
    check("late_ack_req", move_req, 1'b0);
    check("late_ack_grid", grid, 64'h0);
    do_tick();
    check("late_ack_welcome", grid, WELCOME_PAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_frame_controller.md
Name: game_frame_controller

Overview:
- Frame-synchronous game supervisor for the N×N tile game.
- Sits between the pushbutton inputs, the game-logic move engine and the renderer.
- Conditions buttons: sync, debounce, single priority direction, hold auto-repeat. Issues move requests to the game logic through a req/ack handshake.
- Commits grid updates to the display only on vsync rising edges, so no tearing. Detects win and game-over, and sequences the welcome, play and end screens.

Parameters:
- GRID_N, 4, tiles per row/column.
- TILE_BITS, 4, bits per tile (log2 exponent; 0 = empty).
- WIN_EXP, 11, tile exponent that wins (2^11 = 2048).
- DEBOUNCE_FRAMES, 2, consecutive frames a button must read high to count as pressed (≥1).
- REPEAT_FRAMES, 12, frames between auto-repeat moves while held; 0 disables repeat.
- END_HOLD_FRAMES, 60, frames the WON/LOST screen ignores buttons.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high reset
- vsync  in  1  from the VGA sync generator
- btn  in  4  raw buttons {right,left,down,up}, asynchronous
- welcome_grid  in  GRID_N*GRID_N*TILE_BITS  animated welcome pattern
- next_grid  in  GRID_N*GRID_N*TILE_BITS  result from game logic, valid with move_ack
- move_ack  in  1  one-cycle pulse: move finished, next_grid valid
- move_req  out  1  level, held until move_ack
- move_dir  out  2  0 up, 1 down, 2 left, 3 right; stable while move_req
- new_game  out  1  one-cycle pulse on entering PLAY
- grid  out  GRID_N*GRID_N*TILE_BITS  displayed grid register
- state  out  3  0 WELCOME, 1 PLAY, 2 WAIT_ACK, 3 WON, 4 LOST
- frame_tick  out  1  one-cycle vsync rising-edge strobe

Behaviour:
- Reset (sync, active-high, any state):
  - state=WELCOME; grid=0; move_req=0, move_dir=0, new_game=0, frame_tick=0.
  - All counters, synchronisers, vsync_prev and the pending register cleared.
  - A reset during WAIT_ACK drops the request. A move_ack arriving later is ignored.
- Tiles and frame tick:
  - Tile idx = r*GRID_N+c occupies grid bits [(idx+1)*TILE_BITS-1 : idx*TILE_BITS].
  - frame_tick = vsync & ~vsync_prev, both registered, one cycle per frame.
- Button conditioning:
  - 2-flop synchroniser per bit.
  - Per-button saturating counters sample on frame_tick: increment if high, clear if low.
  - A button is "down" when its count ≥ DEBOUNCE_FRAMES.
- Move event, evaluated on frame_tick:
  - Event fires when the highest-priority down button (up>down>left>right) first becomes down.
  - Event also fires every REPEAT_FRAMES frames while that same button stays down.
  - Changing the highest-priority button restarts timing as a fresh press.
  - At most one event per frame.
- WELCOME:
  - On each frame_tick, grid<=welcome_grid.
  - Any move event → PLAY, grid<=0, new_game pulses on the transition cycle. No move_req is issued for that press.
- PLAY:
  - Move event → WAIT_ACK; move_req<=1, move_dir<=direction, on the cycle after the tick.
- WAIT_ACK:
  - Move events are ignored, not queued.
  - On move_ack: latch next_grid into pending, set pending_valid, clear move_req, → PLAY.
- Commit:
  - On a frame_tick with pending_valid: grid<=pending, clear pending_valid.
  - move_ack coinciding with frame_tick commits on the following tick, never the same one.
  - After commit, evaluated on the committed grid next cycle:
    - Any tile == WIN_EXP → WON.
    - Else no tile 0 and no horizontally/vertically adjacent equal nonzero pair → LOST.
    - Else remain.
  - WON has priority over LOST.
- WON/LOST:
  - grid held; counter counts END_HOLD_FRAMES ticks, events ignored meanwhile.
  - After that, any move event → WELCOME.
  - Buttons must be released and re-pressed: events only count from a fresh press, not repeat.
- Widths and counters:
  - Counters saturate.
  - REPEAT_FRAMES=0: only the fresh-press event fires.
  - All outputs are registered.

Test Plan:
- Reset high 3 cycles mid-WAIT_ACK → state=0, move_req=0, grid=0. A later move_ack changes nothing.
- In WELCOME, hold btn=4'b0001 for DEBOUNCE_FRAMES=2 ticks → new_game single pulse, state=1, grid=0, move_req stays 0.
- In PLAY, press btn=4'b0101 (up+left) → move_req=1, move_dir=0. Ack with next_grid=0x…0001 on a non-tick cycle → grid unchanged until next frame_tick, then equals next_grid.
- Hold right 40 frames, REPEAT_FRAMES=12, ack each request within 10 cycles → exactly 4 move_req assertions, at the fresh press and after 12, 24 and 36 frames, move_dir=3 each time.
- Commit a grid containing tile value 11 → state=3 next cycle. Buttons are ignored for 60 ticks; release then press → state=0.
- Commit a full grid with no adjacent equal pair (rows 1,2,1,2 / 2,1,2,1 / …) → state=4. A full grid with one equal adjacent pair → stays 1.
